// File: rtl/hfrv_bus_mem.sv
// hfrv_bus_mem: word-array memory and GPIO responder for the HF-RISC core bus.
// Ports: clk, reset (sync, active-high); address/data_we/data_write in;
//        data_read, stall, bus_err out; extio_in (async) in, extio_out out.
module hfrv_bus_mem #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH       = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR   = ADDR_WIDTH'(32'hF000_0000),
   parameter int                    GPIO_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] data_we,
   input  logic [DATA_WIDTH-1:0]   data_write,
   output logic [DATA_WIDTH-1:0]   data_read,
   output logic                    stall,
   input  logic [GPIO_WIDTH-1:0]   extio_in,
   output logic [GPIO_WIDTH-1:0]   extio_out,
   output logic                    bus_err
);

   localparam int BE_W     = DATA_WIDTH / 8;
   localparam int LSB      = $clog2(BE_W);
   localparam int SPAN_LSB = $clog2(DEPTH) + LSB;
   localparam logic [7:0] CNT_INIT =
      (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                  r_state, w_state_n;
   logic [7:0]              r_cnt, w_cnt_n;
   logic                    w_done, w_capture;
   logic [ADDR_WIDTH-1:0]   r_req_addr, w_addr;
   logic [BE_W-1:0]         r_req_we, w_we;
   logic [DATA_WIDTH-1:0]   r_req_wdata, w_wdata;
   logic [GPIO_WIDTH-1:0]   r_sync1, r_sync2, r_extio_out;
   logic [DATA_WIDTH-1:0]   r_data_read;
   logic                    r_bus_err;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic                    w_is_gpio, w_is_mem;
   logic [SPAN_LSB-LSB-1:0] w_idx;
   logic                    w_unused;

   // Zero-wait accesses complete straight from the bus; otherwise the
   // captured request is completed and bus activity in WAIT is ignored.
   assign w_addr  = (WAIT_STATES == 0) ? address    : r_req_addr;
   assign w_we    = (WAIT_STATES == 0) ? data_we    : r_req_we;
   assign w_wdata = (WAIT_STATES == 0) ? data_write : r_req_wdata;

   // BASE_ADDR is span-aligned, so range test is a compare of high bits.
   assign w_is_gpio = (w_addr[ADDR_WIDTH-1:LSB] == GPIO_ADDR[ADDR_WIDTH-1:LSB]);
   assign w_is_mem  = !w_is_gpio &&
      (w_addr[ADDR_WIDTH-1:SPAN_LSB] == BASE_ADDR[ADDR_WIDTH-1:SPAN_LSB]);
   assign w_idx     = w_addr[SPAN_LSB-1:LSB];
   assign w_unused  = ^w_addr[LSB-1:0];

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_done    = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (WAIT_STATES == 0) begin
               w_done = 1'b1;
            end else begin
               w_capture = 1'b1;
               w_state_n = S_WAIT;
               w_cnt_n   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (r_cnt != 8'd0) begin
               w_cnt_n = r_cnt - 8'd1;
            end else begin
               w_done    = 1'b1;
               w_state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_data_read <= '0;
         r_extio_out <= '0;
         r_bus_err   <= 1'b0;
         r_sync1     <= '0;
         r_sync2     <= '0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_sync1   <= extio_in;
         r_sync2   <= r_sync1;
         r_bus_err <= w_done && !w_is_gpio && !w_is_mem;
         if (w_done) begin
            if (w_is_gpio) begin
               r_data_read <= DATA_WIDTH'(r_sync2);
               if (w_we[0]) r_extio_out <= w_wdata[GPIO_WIDTH-1:0];
            end else if (w_is_mem) begin
               r_data_read <= r_mem[w_idx];
            end else begin
               r_data_read <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_capture) begin
         r_req_addr  <= address;
         r_req_we    <= data_we;
         r_req_wdata <= data_write;
      end
   end

   // Array contents survive reset; a reset in WAIT drops the write.
   always_ff @(posedge clk) begin
      if (!reset && w_done && w_is_mem) begin
         for (int i = 0; i < BE_W; i++) begin
            if (w_we[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   assign data_read = r_data_read;
   assign stall     = (r_state == S_WAIT);
   assign extio_out = r_extio_out;
   assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_hfrv_bus_mem.sv
// tb_hfrv_bus_mem: three responders (0, 3 and 4 wait states) driven with
// directed and random accesses, checked against an array/queue-level model.
module tb_hfrv_bus_mem;

   localparam int          DEPTH  = 256;
   localparam logic [31:0] GPIO_A = 32'hF000_0000;
   localparam logic [31:0] OOR_A  = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        rst     [3];
   logic [31:0] addr    [3];
   logic [3:0]  we_s    [3];
   logic [31:0] wdat    [3];
   logic [31:0] dread   [3];
   logic        stall_o [3];
   logic [7:0]  ext_in  [3];
   logic [7:0]  ext_out [3];
   logic        berr    [3];

   logic [31:0] mem_m [3][DEPTH];
   logic [7:0]  out_m [3];
   int          ws    [3];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   hfrv_bus_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset(rst[0]), .address(addr[0]), .data_we(we_s[0]),
      .data_write(wdat[0]), .data_read(dread[0]), .stall(stall_o[0]),
      .extio_in(ext_in[0]), .extio_out(ext_out[0]), .bus_err(berr[0]));

   hfrv_bus_mem #(.DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
      .clk(clk), .reset(rst[1]), .address(addr[1]), .data_we(we_s[1]),
      .data_write(wdat[1]), .data_read(dread[1]), .stall(stall_o[1]),
      .extio_in(ext_in[1]), .extio_out(ext_out[1]), .bus_err(berr[1]));

   hfrv_bus_mem #(.DEPTH(DEPTH), .WAIT_STATES(4)) u2 (
      .clk(clk), .reset(rst[2]), .address(addr[2]), .data_we(we_s[2]),
      .data_write(wdat[2]), .data_read(dread[2]), .stall(stall_o[2]),
      .extio_in(ext_in[2]), .extio_out(ext_out[2]), .bus_err(berr[2]));

   // Reference: word array + GPIO register, read-first semantics.
   function automatic void model(input int d, input logic [31:0] a,
                                 input logic [3:0] we, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic err);
      int idx;
      rd  = '0;
      err = 1'b0;
      if ((a & ~32'h3) == GPIO_A) begin
         rd = {24'h0, ext_in[d]};
         if (we[0]) out_m[d] = wd[7:0];
      end else if (a < DEPTH * 4) begin
         idx = int'(a >> 2);
         rd  = mem_m[d][idx];
         for (int i = 0; i < 4; i++)
            if (we[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
         err = 1'b1;
      end
   endfunction

   // One bus access; called at a negedge. Scrambles the bus while stalled.
   task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output int ns);
      int guard = 0;
      while (stall_o[d] !== 1'b0 && guard < 300) begin
         guard++;
         @(negedge clk);
      end
      checks++;
      if (guard >= 300) begin
         errors++;
         $display("FAIL idle_timeout dut%0d stall never fell", d);
      end
      addr[d] = a; we_s[d] = we; wdat[d] = wd;
      @(posedge clk);
      ns = 0;
      @(negedge clk);
      while (stall_o[d] === 1'b1 && ns < 300) begin
         ns++;
         addr[d] = $urandom; we_s[d] = 4'($urandom); wdat[d] = $urandom;
         @(negedge clk);
      end
      rd  = dread[d];
      err = berr[d];
      addr[d] = '0; we_s[d] = '0; wdat[d] = '0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; addr[d] = '0; we_s[d] = '0; wdat[d] = '0;
         ext_in[d] = '0; out_m[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (dread[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset_data_read dut%0d got %h exp 0", d, dread[d]);
         end
         checks++;
         if (stall_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall dut%0d got %b exp 0", d, stall_o[d]);
         end
         checks++;
         if (ext_out[d] !== 8'h0) begin
            errors++;
            $display("FAIL reset_extio dut%0d got %h exp 0", d, ext_out[d]);
         end
         checks++;
         if (berr[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus_err dut%0d got %b exp 0", d, berr[d]);
         end
      end
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
   endtask

   task automatic fill();
      logic [31:0] rd, v;
      logic        err;
      int          ns;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            xfer(d, 32'(i * 4), 4'hF, v, rd, err, ns);
            mem_m[d][i] = v;
         end
   endtask

   task automatic test_basic();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns0, ns1;
      model(0, 32'h10, 4'hF, 32'hDEADBEEF, e, ee);
      xfer(0, 32'h10, 4'hF, 32'hDEADBEEF, rd, err, ns0);
      model(0, 32'h10, 4'h0, 32'h0, e, ee);
      xfer(0, 32'h10, 4'h0, 32'h0, rd, err, ns1);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_read got %h exp deadbeef", rd);
      end
      checks++;
      if (ns0 != 0 || ns1 != 0) begin
         errors++;
         $display("FAIL basic_no_stall got %0d/%0d exp 0/0", ns0, ns1);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns;
      model(0, 32'h20, 4'hF, 32'h11223344, e, ee);
      xfer(0, 32'h20, 4'hF, 32'h11223344, rd, err, ns);
      model(0, 32'h20, 4'h5, 32'hAABBCCDD, e, ee);
      xfer(0, 32'h20, 4'h5, 32'hAABBCCDD, rd, err, ns);
      checks++;
      if (rd !== 32'h11223344) begin
         errors++;
         $display("FAIL lanes_read_first got %h exp 11223344", rd);
      end
      model(0, 32'h20, 4'h0, 32'h0, e, ee);
      xfer(0, 32'h20, 4'h0, 32'h0, rd, err, ns);
      checks++;
      if (rd !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL lanes_merge got %h exp 11bb33dd", rd);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns;
      model(1, 32'h10, 4'h0, 32'h0, e, ee);
      xfer(1, 32'h10, 4'h0, 32'h0, rd, err, ns);
      checks++;
      if (rd !== e || ns != 3) begin
         errors++;
         $display("FAIL ws3_read got %h/%0d exp %h/3", rd, ns, e);
      end
      model(1, 32'h10, 4'hF, 32'h0BADF00D, e, ee);
      xfer(1, 32'h10, 4'hF, 32'h0BADF00D, rd, err, ns);
      checks++;
      if (rd !== e || ns != 3) begin
         errors++;
         $display("FAIL ws3_b2b_write got %h/%0d exp %h/3", rd, ns, e);
      end
      xfer(1, 32'h10, 4'h0, 32'h0, rd, err, ns);
      checks++;
      if (rd !== 32'h0BADF00D || ns != 3) begin
         errors++;
         $display("FAIL ws3_b2b_read got %h/%0d exp 0badf00d/3", rd, ns);
      end
   endtask

   task automatic test_gpio();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns;
      for (int d = 0; d < 3; d++) begin
         model(d, GPIO_A, 4'h1, 32'hFFFF_FFA5, e, ee);
         xfer(d, GPIO_A, 4'h1, 32'hFFFF_FFA5, rd, err, ns);
         checks++;
         if (ext_out[d] !== 8'hA5) begin
            errors++;
            $display("FAIL gpio_out dut%0d got %h exp a5", d, ext_out[d]);
         end
         ext_in[d] = 8'h3C;
         repeat (2) @(negedge clk);
         model(d, GPIO_A, 4'h0, 32'h0, e, ee);
         xfer(d, GPIO_A, 4'h0, 32'h0, rd, err, ns);
         checks++;
         if (rd !== 32'h0000_003C) begin
            errors++;
            $display("FAIL gpio_in dut%0d got %h exp 0000003c", d, rd);
         end
         model(d, GPIO_A | 32'h2, 4'hE, 32'h0000_0011, e, ee);
         xfer(d, GPIO_A | 32'h2, 4'hE, 32'h0000_0011, rd, err, ns);
         checks++;
         if (ext_out[d] !== 8'hA5) begin
            errors++;
            $display("FAIL gpio_lane0_only dut%0d got %h exp a5", d, ext_out[d]);
         end
      end
   endtask

   task automatic test_oor();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns;
      for (int d = 0; d < 2; d++) begin
         xfer(d, OOR_A, 4'h0, 32'h0, rd, err, ns);
         checks++;
         if (rd !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read dut%0d got %h/%b exp 0/1", d, rd, err);
         end
         @(negedge clk);
         checks++;
         if (berr[d] !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse dut%0d got %b exp 0", d, berr[d]);
         end
         xfer(d, OOR_A, 4'hF, $urandom, rd, err, ns);
         checks++;
         if (rd !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_write dut%0d got %h/%b exp 0/1", d, rd, err);
         end
         model(d, 32'h0, 4'h0, 32'h0, e, ee);
         xfer(d, 32'h0, 4'h0, 32'h0, rd, err, ns);
         checks++;
         if (rd !== e || err !== 1'b0) begin
            errors++;
            $display("FAIL oor_word0 dut%0d got %h/%b exp %h/0", d, rd, err, e);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd, e;
      logic [3:0]  we;
      logic        err, ee;
      int          ns, sel;
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 32'($urandom_range(0, DEPTH * 4 - 1));
            else if (sel < 8) a = GPIO_A | 32'($urandom_range(0, 3));
            else              a = OOR_A + 32'($urandom_range(0, 32'h0FFF_FFFF));
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wd = $urandom;
            model(d, a, we, wd, e, ee);
            xfer(d, a, we, wd, rd, err, ns);
            checks++;
            if (rd !== e || err !== ee || ns != ws[d] || ext_out[d] !== out_m[d]) begin
               errors++;
               $display("FAIL rand dut%0d a=%h we=%h got %h/%b/%0d/%h exp %h/%b/%0d/%h",
                        d, a, we, rd, err, ns, ext_out[d], e, ee, ws[d], out_m[d]);
            end
         end
   endtask

   task automatic test_reset_wait();
      logic [31:0] rd, e;
      logic        err, ee;
      int          ns;
      model(2, GPIO_A, 4'h1, 32'h5A, e, ee);
      xfer(2, GPIO_A, 4'h1, 32'h5A, rd, err, ns);
      model(2, 32'h40, 4'hF, 32'hCAFEF00D, e, ee);
      xfer(2, 32'h40, 4'hF, 32'hCAFEF00D, rd, err, ns);
      model(2, 32'h40, 4'h0, 32'h0, e, ee);
      xfer(2, 32'h40, 4'h0, 32'h0, rd, err, ns);
      addr[2] = 32'h40; we_s[2] = 4'hF; wdat[2] = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall_o[2] !== 1'b1) begin
         errors++;
         $display("FAIL rw_stall_1 got %b exp 1", stall_o[2]);
      end
      @(negedge clk);
      rst[2] = 1'b1; addr[2] = '0; we_s[2] = '0; wdat[2] = '0;
      @(negedge clk);
      checks++;
      if (stall_o[2] !== 1'b0 || ext_out[2] !== 8'h0 || dread[2] !== 32'h0) begin
         errors++;
         $display("FAIL rw_after_reset got %b/%h/%h exp 0/00/0",
                  stall_o[2], ext_out[2], dread[2]);
      end
      rst[2] = 1'b0;
      out_m[2] = '0;
      model(2, 32'h40, 4'h0, 32'h0, e, ee);
      xfer(2, 32'h40, 4'h0, 32'h0, rd, err, ns);
      checks++;
      if (rd !== 32'hCAFEF00D || ns != 4) begin
         errors++;
         $display("FAIL rw_dropped_write got %h/%0d exp cafef00d/4", rd, ns);
      end
   endtask

   initial begin
      ws[0] = 0; ws[1] = 3; ws[2] = 4;
      test_reset();
      fill();
      test_basic();
      test_byte_lanes();
      test_wait_states();
      test_gpio();
      test_oor();
      test_random();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
